// File: rtl/sys_bus_initiator_if.sv
// ---------------------------------------------------------------------------
// sys_bus_initiator_if
//
// Purpose:
//   Bundles every handshake and bus signal of the system-bus initiator so the
//   initiator and its surroundings connect through one port. Clock and reset
//   stay outside the bundle as plain ports.
//
// Signal groups (names keep the initiator's point of view: _i = into the
// initiator, _o = out of the initiator):
//   cmd_*  : command port (valid/ready). The initiator accepts one command at
//            a time.
//   rsp_*  : response port (valid/ready). The response is held until it is
//            consumed.
//   sys_*  : system register bus. It carries one-cycle wen/ren strobes and is
//            terminated by ack or err.
//
// Modports:
//   master : the initiator itself.
//   slave  : the environment, i.e. the command source, the response sink and
//            the register slaves.
// ---------------------------------------------------------------------------
interface sys_bus_initiator_if #(
    parameter int AW = 32
);
    logic          cmd_valid_i;
    logic          cmd_ready_o;
    logic          cmd_write_i;
    logic [AW-1:0] cmd_addr_i;
    logic [31:0]   cmd_wdata_i;
    logic [3:0]    cmd_sel_i;

    logic          rsp_valid_o;
    logic          rsp_ready_i;
    logic [31:0]   rsp_rdata_o;
    logic          rsp_err_o;
    logic          rsp_timeout_o;

    logic [AW-1:0] sys_addr_o;
    logic [31:0]   sys_wdata_o;
    logic [3:0]    sys_sel_o;
    logic          sys_wen_o;
    logic          sys_ren_o;
    logic [31:0]   sys_rdata_i;
    logic          sys_err_i;
    logic          sys_ack_i;

    modport master (
        input  cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_sel_i,
        output cmd_ready_o,
        output rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
        input  rsp_ready_i,
        output sys_addr_o, sys_wdata_o, sys_sel_o, sys_wen_o, sys_ren_o,
        input  sys_rdata_i, sys_err_i, sys_ack_i
    );

    modport slave (
        output cmd_valid_i, cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_sel_i,
        input  cmd_ready_o,
        input  rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o,
        output rsp_ready_i,
        input  sys_addr_o, sys_wdata_o, sys_sel_o, sys_wen_o, sys_ren_o,
        output sys_rdata_i, sys_err_i, sys_ack_i
    );
endinterface

// File: rtl/sys_bus_initiator.sv
// ---------------------------------------------------------------------------
// sys_bus_initiator
//
// Purpose:
//   System-bus master. It turns a single command from a valid/ready port into
//   exactly one sys_* bus transaction, using a one-cycle wen or ren strobe.
//   It then waits for sys_ack/sys_err, or gives up after TIMEOUT cycles, and
//   returns the outcome on a valid/ready response port. Local sequencers
//   (self-test, LED/expansion scripts) use it to reach the house-keeping and
//   peripheral register slaves without going through the PS bus.
//
// Parameters:
//   TIMEOUT : number of cycles waited after the strobe before aborting.
//             Legal range is 1..65535.
//   AW      : address width.
//
// Ports:
//   clk_i   : clock.
//   rstn_i  : asynchronous, active-low reset. Asserting it drops any
//             transaction in flight, and no response is produced for it.
//   bus     : sys_bus_initiator_if.master, which carries the cmd_*, rsp_* and
//             sys_* signals.
//   busy_o  : high whenever the initiator is not idle.
//
// Sequence:
//   IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//   With a one-cycle responder the timing is:
//     - command accepted in cycle T,
//     - strobe in T+1,
//     - ack in T+2,
//     - rsp_valid in T+3.
//   This gives one transaction every four cycles when rsp_ready_i is held
//   high.
// ---------------------------------------------------------------------------
module sys_bus_initiator #(
    parameter int TIMEOUT = 255,
    parameter int AW      = 32
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    sys_bus_initiator_if.master bus,
    output logic                busy_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    // The counter is just wide enough to hold TIMEOUT itself.
    localparam int              CW          = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0]   TIMEOUT_CNT = CW'(TIMEOUT);

    logic [1:0]    state;
    logic [CW-1:0] wait_cnt;
    logic [CW-1:0] wait_cnt_inc;

    logic          write_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [3:0]    sel_q;
    logic          wen_q;
    logic          ren_q;

    logic [31:0]   rsp_rdata_q;
    logic          rsp_err_q;
    logic          rsp_timeout_q;

    logic          bus_done;

    // wait_cnt_inc is the number of WAIT cycles including the current one.
    // The timeout fires when it reaches TIMEOUT. An ack in that same last
    // cycle still takes priority over the timeout.
    assign wait_cnt_inc = wait_cnt + CW'(1);
    assign bus_done     = bus.sys_ack_i | bus.sys_err_i;

    // Main sequencer.
    //  - The strobe is registered on acceptance, so it is high for exactly the
    //    single ISSUE cycle.
    //  - ack/err are only looked at in WAIT. Anything seen in IDLE, ISSUE or
    //    RESP is a stray and is dropped.
    //  - The address, write data and byte select are left untouched after
    //    completion; only a new command or reset changes them.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state         <= S_IDLE;
            wait_cnt      <= '0;
            write_q       <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            sel_q         <= '0;
            wen_q         <= 1'b0;
            ren_q         <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.cmd_valid_i) begin
                        write_q <= bus.cmd_write_i;
                        addr_q  <= bus.cmd_addr_i;
                        wdata_q <= bus.cmd_wdata_i;
                        sel_q   <= bus.cmd_sel_i;
                        wen_q   <= bus.cmd_write_i;
                        ren_q   <= ~bus.cmd_write_i;
                        state   <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    wen_q    <= 1'b0;
                    ren_q    <= 1'b0;
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end

                S_WAIT: begin
                    if (bus_done) begin
                        // A completed read returns the slave's data. Writes
                        // and errored accesses return zero.
                        rsp_rdata_q   <= (!write_q && !bus.sys_err_i) ? bus.sys_rdata_i : 32'd0;
                        rsp_err_q     <= bus.sys_err_i;
                        rsp_timeout_q <= 1'b0;
                        state         <= S_RESP;
                    end else if (wait_cnt_inc == TIMEOUT_CNT) begin
                        rsp_rdata_q   <= 32'd0;
                        rsp_err_q     <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        state         <= S_RESP;
                    end else begin
                        // The state is left before wait_cnt can reach
                        // TIMEOUT, so the counter never wraps.
                        wait_cnt <= wait_cnt_inc;
                    end
                end

                S_RESP: begin
                    if (bus.rsp_ready_i) begin
                        state <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready_o   = (state == S_IDLE);
    assign bus.rsp_valid_o   = (state == S_RESP);
    assign bus.rsp_rdata_o   = rsp_rdata_q;
    assign bus.rsp_err_o     = rsp_err_q;
    assign bus.rsp_timeout_o = rsp_timeout_q;

    assign bus.sys_addr_o    = addr_q;
    assign bus.sys_wdata_o   = wdata_q;
    assign bus.sys_sel_o     = sel_q;
    assign bus.sys_wen_o     = wen_q;
    assign bus.sys_ren_o     = ren_q;

    assign busy_o            = (state != S_IDLE);

endmodule

// File: tb/tb_sys_bus_initiator.sv
// ---------------------------------------------------------------------------
// tb_sys_bus_initiator
//
// Purpose:
//   Self-checking bench for sys_bus_initiator, built with TIMEOUT = 8.
//
//   The bench plays three roles:
//     - the command source,
//     - the response sink,
//     - a register slave whose answer delay, error flag and read data are
//       chosen per transaction.
//
//   Expected outcomes are worked out at transaction level, with cycle
//   numbers relative to the accept cycle k = 0:
//     - the strobe appears in cycle 1;
//     - a slave answering d cycles after the strobe, with 1 <= d <= TIMEOUT,
//       gets its response at cycle d + 2;
//     - otherwise the response comes at cycle TIMEOUT + 2 with err = 1 and
//       timeout = 1.
// ---------------------------------------------------------------------------
module tb_sys_bus_initiator;

    localparam int TIMEOUT = 8;
    localparam int AW      = 32;

    logic clk = 1'b0;
    logic rstn;
    logic busy;

    int checks = 0;
    int errors = 0;

    sys_bus_initiator_if #(.AW(AW)) bus ();

    sys_bus_initiator #(
        .TIMEOUT (TIMEOUT),
        .AW      (AW)
    ) dut (
        .clk_i  (clk),
        .rstn_i (rstn),
        .bus    (bus),
        .busy_o (busy)
    );

    always #5 clk = ~clk;

    // Everything observed while driving one transaction.
    typedef struct {
        bit            accepted;
        int            strobe_cyc;
        int            wen_cnt;
        int            ren_cnt;
        int            rsp_cyc;
        int            total;
        logic [31:0]   rdata;
        logic          err;
        logic          tmo;
        logic [AW-1:0] s_addr;
        logic [31:0]   s_wdata;
        logic [3:0]    s_sel;
        bit            stable;
        bit            ready_in_resp;
    } obs_t;

    // Transaction-level model of the expected response.
    // A delay of 0 means the slave stays silent.
    function automatic void model(input bit write, input int delay, input bit err_f,
                                  input logic [31:0] rd, output int rsp_cyc,
                                  output logic [31:0] e_rdata, output logic e_err,
                                  output logic e_tmo);
        if (delay >= 1 && delay <= TIMEOUT) begin
            rsp_cyc = 1 + delay + 1;
            e_err   = err_f;
            e_tmo   = 1'b0;
            e_rdata = (!write && !err_f) ? rd : 32'd0;
        end else begin
            rsp_cyc = 1 + TIMEOUT + 1;
            e_err   = 1'b1;
            e_tmo   = 1'b1;
            e_rdata = 32'd0;
        end
    endfunction

    // Drives one command and plays the slave and the response sink.
    //  - Called and returns at 1 ns after a rising edge, with the DUT idle.
    //  - ready_delay is the number of RESP cycles with rsp_ready_i held low.
    //  - stray adds ack/err pulses in the IDLE, ISSUE and RESP cycles.
    task automatic do_txn(input bit write, input logic [AW-1:0] addr,
                          input logic [31:0] wdata, input logic [3:0] sel,
                          input int delay, input bit err_f, input logic [31:0] rd,
                          input int ready_delay, input bit stray, output obs_t o);
        bit done;
        o.accepted = bus.cmd_ready_o;
        o.strobe_cyc = -1; o.rsp_cyc = -1; o.total = -1;
        o.wen_cnt = 0; o.ren_cnt = 0;
        o.rdata = '0; o.err = 1'b0; o.tmo = 1'b0;
        o.s_addr = '0; o.s_wdata = '0; o.s_sel = '0;
        o.stable = 1'b1; o.ready_in_resp = 1'b0;
        for (int k = 0; k < 200; k++) begin
            // Command port: the command is valid only in cycle 0. After that
            // the inputs are scrambled so the DUT must use its latched copy.
            bus.cmd_valid_i = (k == 0);
            bus.cmd_write_i = (k == 0) ? write : ~write;
            bus.cmd_addr_i  = (k == 0) ? addr  : ~addr;
            bus.cmd_wdata_i = (k == 0) ? wdata : ~wdata;
            bus.cmd_sel_i   = (k == 0) ? sel   : ~sel;
            if (bus.sys_wen_o) o.wen_cnt++;
            if (bus.sys_ren_o) o.ren_cnt++;
            if ((bus.sys_wen_o || bus.sys_ren_o) && o.strobe_cyc < 0) begin
                o.strobe_cyc = k;
                o.s_addr     = bus.sys_addr_o;
                o.s_wdata    = bus.sys_wdata_o;
                o.s_sel      = bus.sys_sel_o;
            end
            // Slave: answers delay cycles after the strobe.
            bus.sys_ack_i   = 1'b0;
            bus.sys_err_i   = 1'b0;
            bus.sys_rdata_i = $urandom;
            if (o.strobe_cyc >= 0 && delay > 0 && k == o.strobe_cyc + delay) begin
                bus.sys_ack_i   = 1'b1;
                bus.sys_err_i   = err_f;
                bus.sys_rdata_i = rd;
            end
            if (stray && (k == 0 || k == o.strobe_cyc || bus.rsp_valid_o)) begin
                bus.sys_ack_i = 1'b1;
                bus.sys_err_i = 1'b1;
            end
            // Response sink.
            bus.rsp_ready_i = 1'($urandom_range(0, 1));
            if (bus.rsp_valid_o) begin
                if (o.rsp_cyc < 0) begin
                    o.rsp_cyc = k;
                    o.rdata   = bus.rsp_rdata_o;
                    o.err     = bus.rsp_err_o;
                    o.tmo     = bus.rsp_timeout_o;
                end else if (bus.rsp_rdata_o !== o.rdata || bus.rsp_err_o !== o.err
                             || bus.rsp_timeout_o !== o.tmo) begin
                    o.stable = 1'b0;
                end
                if (bus.cmd_ready_o) o.ready_in_resp = 1'b1;
                bus.rsp_ready_i = (k >= o.rsp_cyc + ready_delay);
            end
            done = bus.rsp_valid_o && bus.rsp_ready_i;
            @(posedge clk); #1;
            if (done) begin
                o.total = k + 1;
                break;
            end
        end
        bus.cmd_valid_i = 1'b0;
        bus.sys_ack_i   = 1'b0;
        bus.sys_err_i   = 1'b0;
        bus.rsp_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        bus.cmd_valid_i = 1'b0; bus.cmd_write_i = 1'b0; bus.cmd_addr_i = '0;
        bus.cmd_wdata_i = '0; bus.cmd_sel_i = '0; bus.rsp_ready_i = 1'b0;
        bus.sys_rdata_i = '0; bus.sys_err_i = 1'b0; bus.sys_ack_i = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        checks++;
        if ({bus.cmd_ready_o, bus.rsp_valid_o, busy, bus.sys_wen_o, bus.sys_ren_o} !== 5'b10000) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got %b expected %b",
                     {bus.cmd_ready_o, bus.rsp_valid_o, busy, bus.sys_wen_o, bus.sys_ren_o}, 5'b10000);
        end
        checks++;
        if ({bus.sys_addr_o, bus.sys_wdata_o, bus.sys_sel_o} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_bus: got %0h/%0h/%0h expected 0",
                     bus.sys_addr_o, bus.sys_wdata_o, bus.sys_sel_o);
        end
        checks++;
        if ({bus.rsp_rdata_o, bus.rsp_err_o, bus.rsp_timeout_o} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_rsp: got %0h/%b/%b expected 0",
                     bus.rsp_rdata_o, bus.rsp_err_o, bus.rsp_timeout_o);
        end
        rstn = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_write();
        obs_t o;
        do_txn(1'b1, 32'h30, 32'h0000_00A5, 4'hF, 1, 1'b0, 32'hDEAD_BEEF, 0, 1'b0, o);
        checks++;
        if (o.wen_cnt !== 1 || o.ren_cnt !== 0 || o.strobe_cyc !== 1) begin
            errors++;
            $display("[TB] FAIL write_strobe: got wen=%0d ren=%0d at %0d expected wen=1 ren=0 at 1",
                     o.wen_cnt, o.ren_cnt, o.strobe_cyc);
        end
        checks++;
        if (o.rsp_cyc !== 3) begin
            errors++;
            $display("[TB] FAIL write_latency: got %0d expected 3", o.rsp_cyc);
        end
        checks++;
        if ({o.rdata, o.err, o.tmo} !== 34'd0) begin
            errors++;
            $display("[TB] FAIL write_rsp: got %0h/%b/%b expected 0/0/0", o.rdata, o.err, o.tmo);
        end
        checks++;
        if (o.s_addr !== 32'h30 || o.s_wdata !== 32'hA5 || o.s_sel !== 4'hF) begin
            errors++;
            $display("[TB] FAIL write_bus: got %0h/%0h/%0h expected 30/a5/f", o.s_addr, o.s_wdata, o.s_sel);
        end
        checks++;
        if (bus.sys_addr_o !== 32'h30 || bus.sys_wdata_o !== 32'hA5) begin
            errors++;
            $display("[TB] FAIL write_hold: got %0h/%0h expected 30/a5", bus.sys_addr_o, bus.sys_wdata_o);
        end
    endtask

    task automatic test_read();
        obs_t o;
        do_txn(1'b0, 32'h04, 32'h1234_5678, 4'hF, 1, 1'b0, 32'h089A_BCDE, 0, 1'b0, o);
        checks++;
        if (o.ren_cnt !== 1 || o.wen_cnt !== 0) begin
            errors++;
            $display("[TB] FAIL read_strobe: got ren=%0d wen=%0d expected 1/0", o.ren_cnt, o.wen_cnt);
        end
        checks++;
        if (o.rdata !== 32'h089A_BCDE || o.err !== 1'b0 || o.rsp_cyc !== 3) begin
            errors++;
            $display("[TB] FAIL read_rsp: got %0h err=%b at %0d expected 89abcde err=0 at 3",
                     o.rdata, o.err, o.rsp_cyc);
        end
    endtask

    task automatic test_timeout();
        obs_t o;
        do_txn(1'b0, 32'h08, 32'h0, 4'h3, 0, 1'b0, 32'h5555_AAAA, 0, 1'b0, o);
        checks++;
        if (o.rsp_cyc - o.strobe_cyc !== TIMEOUT + 1) begin
            errors++;
            $display("[TB] FAIL timeout_latency: got strobe+%0d expected strobe+%0d",
                     o.rsp_cyc - o.strobe_cyc, TIMEOUT + 1);
        end
        checks++;
        if (o.err !== 1'b1 || o.tmo !== 1'b1 || o.rdata !== 32'd0) begin
            errors++;
            $display("[TB] FAIL timeout_rsp: got err=%b tmo=%b rdata=%0h expected 1/1/0", o.err, o.tmo, o.rdata);
        end
    endtask

    task automatic test_ack_err();
        obs_t o;
        do_txn(1'b0, 32'h0C, 32'h0, 4'hF, 2, 1'b1, 32'h7777_7777, 0, 1'b0, o);
        checks++;
        if (o.err !== 1'b1 || o.tmo !== 1'b0 || o.rdata !== 32'd0 || o.rsp_cyc !== 4) begin
            errors++;
            $display("[TB] FAIL ack_err: got err=%b tmo=%b rdata=%0h at %0d expected 1/0/0 at 4",
                     o.err, o.tmo, o.rdata, o.rsp_cyc);
        end
        // An ack arriving in the very last waiting cycle beats the timeout.
        do_txn(1'b0, 32'h10, 32'h0, 4'hF, TIMEOUT, 1'b0, 32'hCAFE_0001, 0, 1'b0, o);
        checks++;
        if (o.err !== 1'b0 || o.tmo !== 1'b0 || o.rdata !== 32'hCAFE_0001 || o.rsp_cyc !== TIMEOUT + 2) begin
            errors++;
            $display("[TB] FAIL ack_at_limit: got err=%b tmo=%b rdata=%0h at %0d expected 0/0/cafe0001 at %0d",
                     o.err, o.tmo, o.rdata, o.rsp_cyc, TIMEOUT + 2);
        end
        // One cycle later is too late: the timeout has already fired.
        do_txn(1'b0, 32'h14, 32'h0, 4'hF, TIMEOUT + 1, 1'b0, 32'hCAFE_0002, 0, 1'b0, o);
        checks++;
        if (o.tmo !== 1'b1 || o.err !== 1'b1 || o.rdata !== 32'd0) begin
            errors++;
            $display("[TB] FAIL ack_past_limit: got err=%b tmo=%b rdata=%0h expected 1/1/0", o.err, o.tmo, o.rdata);
        end
    endtask

    task automatic test_backpressure();
        obs_t o;
        do_txn(1'b0, 32'h20, 32'h0, 4'hF, 1, 1'b0, 32'h0BAD_F00D, 5, 1'b1, o);
        checks++;
        if (o.total - o.rsp_cyc !== 6) begin
            errors++;
            $display("[TB] FAIL bp_hold: got %0d valid cycles expected 6", o.total - o.rsp_cyc);
        end
        checks++;
        if (o.stable !== 1'b1 || o.ready_in_resp !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_stable: got stable=%b cmd_ready=%b expected 1/0", o.stable, o.ready_in_resp);
        end
        checks++;
        if (o.rdata !== 32'h0BAD_F00D || o.err !== 1'b0 || o.rsp_cyc !== 3) begin
            errors++;
            $display("[TB] FAIL bp_stray: got %0h err=%b at %0d expected badf00d err=0 at 3",
                     o.rdata, o.err, o.rsp_cyc);
        end
    endtask

    task automatic test_reset_mid_wait();
        obs_t o;
        bit   saw;
        bus.cmd_write_i = 1'b0; bus.cmd_addr_i = 32'h40; bus.cmd_valid_i = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid_i = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_busy: got %b expected 1", busy);
        end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if ({bus.cmd_ready_o, bus.rsp_valid_o, bus.sys_ren_o, busy} !== 4'b1000) begin
            errors++;
            $display("[TB] FAIL mid_reset_ctrl: got %b expected 1000",
                     {bus.cmd_ready_o, bus.rsp_valid_o, bus.sys_ren_o, busy});
        end
        checks++;
        if (bus.sys_addr_o !== '0 || bus.rsp_err_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_reset_bus: got addr=%0h err=%b expected 0/0", bus.sys_addr_o, bus.rsp_err_o);
        end
        @(negedge clk);
        rstn = 1'b1;
        @(posedge clk); #1;
        saw = 1'b0;
        for (int k = 0; k < TIMEOUT + 6; k++) begin
            bus.sys_ack_i = k[0];
            if (bus.rsp_valid_o || busy) saw = 1'b1;
            @(posedge clk); #1;
        end
        bus.sys_ack_i = 1'b0;
        checks++;
        if (saw !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mid_no_rsp: got activity=%b expected 0", saw);
        end
        do_txn(1'b1, 32'h44, 32'h0000_0F0F, 4'h1, 1, 1'b0, 32'h1, 0, 1'b0, o);
        checks++;
        if (o.rsp_cyc !== 3 || o.err !== 1'b0 || o.wen_cnt !== 1) begin
            errors++;
            $display("[TB] FAIL mid_recover: got rsp@%0d err=%b wen=%0d expected 3/0/1",
                     o.rsp_cyc, o.err, o.wen_cnt);
        end
    endtask

    task automatic test_back_to_back();
        obs_t o;
        for (int i = 0; i < 3; i++) begin
            do_txn(i[0], 32'h100 + 32'(i * 4), $urandom, 4'hF, 1, 1'b0, $urandom, 0, 1'b0, o);
            checks++;
            if (o.accepted !== 1'b1 || o.total !== 4) begin
                errors++;
                $display("[TB] FAIL b2b_%0d: got accepted=%b cycles=%0d expected 1/4", i, o.accepted, o.total);
            end
        end
    endtask

    task automatic test_random();
        obs_t        o;
        bit          wr, ef, st;
        int          dly, rdy, e_cyc;
        logic [31:0] a, wd, rd, e_rdata;
        logic [3:0]  sel;
        logic        e_err, e_tmo;
        for (int i = 0; i < 25; i++) begin
            wr  = 1'($urandom_range(0, 1));
            ef  = ($urandom_range(0, 3) == 0);
            st  = 1'($urandom_range(0, 1));
            dly = $urandom_range(0, TIMEOUT + 2);
            rdy = $urandom_range(0, 3);
            a   = $urandom; wd = $urandom; rd = $urandom;
            sel = 4'($urandom);
            model(wr, dly, ef, rd, e_cyc, e_rdata, e_err, e_tmo);
            do_txn(wr, a, wd, sel, dly, ef, rd, rdy, st, o);
            checks++;
            if (o.rsp_cyc !== e_cyc) begin
                errors++;
                $display("[TB] FAIL rand%0d_latency: got %0d expected %0d (dly=%0d)", i, o.rsp_cyc, e_cyc, dly);
            end
            checks++;
            if ({o.rdata, o.err, o.tmo} !== {e_rdata, e_err, e_tmo}) begin
                errors++;
                $display("[TB] FAIL rand%0d_rsp: got %0h/%b/%b expected %0h/%b/%b",
                         i, o.rdata, o.err, o.tmo, e_rdata, e_err, e_tmo);
            end
            checks++;
            if (o.wen_cnt !== int'(wr) || o.ren_cnt !== int'(!wr) || o.strobe_cyc !== 1) begin
                errors++;
                $display("[TB] FAIL rand%0d_strobe: got wen=%0d ren=%0d at %0d expected %0d/%0d at 1",
                         i, o.wen_cnt, o.ren_cnt, o.strobe_cyc, int'(wr), int'(!wr));
            end
            checks++;
            if (o.s_addr !== a || o.s_wdata !== wd || o.s_sel !== sel) begin
                errors++;
                $display("[TB] FAIL rand%0d_bus: got %0h/%0h/%0h expected %0h/%0h/%0h",
                         i, o.s_addr, o.s_wdata, o.s_sel, a, wd, sel);
            end
            checks++;
            if (o.stable !== 1'b1 || o.ready_in_resp !== 1'b0 || o.total - o.rsp_cyc !== rdy + 1) begin
                errors++;
                $display("[TB] FAIL rand%0d_hold: got stable=%b cmd_ready=%b valid=%0d expected 1/0/%0d",
                         i, o.stable, o.ready_in_resp, o.total - o.rsp_cyc, rdy + 1);
            end
        end
    endtask

    // Run every scenario in order, then print the summary.
    initial begin
        test_reset();
        test_write();
        test_read();
        test_timeout();
        test_ack_err();
        test_backpressure();
        test_reset_mid_wait();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Safety net against a hung run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no completion expected finish before 500000");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
